// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the pipeline hazard / stall
//                controller: md-unit FSM state, stall_cause encodings and the
//                hard-wired zero register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Multiply/divide tracker state.
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // stall_cause output encodings.
    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_LU   = 2'd1;
    localparam logic [1:0] CAUSE_MD   = 2'd2;
    localparam logic [1:0] CAUSE_IMEM = 2'd3;

    // Register 0 is hard-wired to zero, so a load to it never creates a hazard.
    localparam int REG_ZERO = 0;

    // Width of the md busy countdown; covers MD_CYCLES up to 255.
    localparam int MD_CNT_W = 8;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/md_busy_timer.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_timer
//  Description : Tracks the multi-cycle multiply/divide unit. md_start in RUN
//                loads MD_CYCLES-1 and enters MD_BUSY; the count decrements
//                each cycle and the FSM returns to RUN after the cycle in which
//                the count is zero, giving exactly MD_CYCLES busy cycles.
//  Ports       : clk, rst (async, active-high), md_start -> md_busy
//  Revision    : 1.0 - initial release
// ============================================================================
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start,
    output logic md_busy
);

    localparam logic [MD_CNT_W-1:0] c_md_load = MD_CNT_W'(MD_CYCLES - 1);

    md_state_e             r_state_q;
    md_state_e             w_state_d;
    logic [MD_CNT_W-1:0]   r_cnt_q;
    logic [MD_CNT_W-1:0]   w_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= RUN;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    // md_start while busy is ignored: only RUN looks at it.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            RUN: begin
                if (md_start) begin
                    w_state_d = MD_BUSY;
                    w_cnt_d   = c_md_load;
                end
            end
            MD_BUSY: begin
                if (r_cnt_q == '0) begin
                    w_state_d = RUN;
                end else begin
                    w_cnt_d = r_cnt_q - MD_CNT_W'(1);
                end
            end
            default: begin
                w_state_d = RUN;
                w_cnt_d   = '0;
            end
        endcase
    end

    assign md_busy = (r_state_q == MD_BUSY);

    // The ID-stage md interlock should make a second issue impossible.
    a_no_md_start_when_busy: assert property (
        @(posedge clk) disable iff (rst) !(md_start && (r_state_q == MD_BUSY))
    );

endmodule : md_busy_timer
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Pipeline sequencing controller for the 5-stage core.
//                Decodes load-use, md-busy and imem-miss hazards and drives
//                PC write, IF/ID hold/flush and ID/EX bubble controls with
//                fixed priority: branch > md > load-use > imem > run.
//                Optional performance counters for stall cycles and
//                taken-branch flushes are built only when HAZ_PERF_CNT_EN is
//                defined; otherwise stall_cnt/flush_cnt are tied to zero.
//  Ports       : clk, rst (async, active-high)
//                in : id_rs, id_rt, id_use_rs, id_use_rt, id_is_md,
//                     ex_mem_read, ex_rd, branch_taken, md_start, imem_ready
//                out: pc_write, if_id_write, if_id_flush, id_ex_flush,
//                     md_busy, stall_cause, stall_cnt, flush_cnt
//  Macro       : HAZ_PERF_CNT_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_CYCLES = 32,
    parameter int REG_W     = 5,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_md,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             md_busy,
    output logic [1:0]       stall_cause,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic w_lu;
    logic w_mdh;
    logic w_im;

    md_busy_timer #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_busy_timer (
        .clk      (clk),
        .rst      (rst),
        .md_start (md_start),
        .md_busy  (md_busy)
    );

    assign w_lu  = ex_mem_read
                 & (ex_rd != REG_W'(REG_ZERO))
                 & ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
    assign w_mdh = id_is_md & md_busy;
    assign w_im  = ~imem_ready;

    // Interlock stalls hold IF/ID rather than flushing it, so an imem miss in
    // the same cycle cannot overwrite the waiting ID instruction.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        stall_cause = CAUSE_NONE;
        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_mdh) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_cause = CAUSE_MD;
        end else if (w_lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_cause = CAUSE_LU;
        end else if (w_im) begin
            // ID keeps advancing; a nop is loaded behind it.
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            stall_cause = CAUSE_IMEM;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt_q;
    logic [CNT_W-1:0] w_stall_cnt_d;
    logic [CNT_W-1:0] r_flush_cnt_q;
    logic [CNT_W-1:0] w_flush_cnt_d;

    // Saturating counters; pc_write is forced low during reset but the flops
    // are held cleared then, so only live cycles are counted.
    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        if (!pc_write && (r_stall_cnt_q != '1)) begin
            w_stall_cnt_d = r_stall_cnt_q + CNT_W'(1);
        end
        if (branch_taken && (r_flush_cnt_q != '1)) begin
            w_flush_cnt_d = r_flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign stall_cnt = r_stall_cnt_q;
    assign flush_cnt = r_flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule : hazard_stall_ctrl
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Directed self-checking bench for hazard_stall_ctrl with
//                MD_CYCLES=4. Counter expectations follow HAZ_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
    logic        id_use_rs = 0, id_use_rt = 0, id_is_md = 0, ex_mem_read = 0;
    logic        branch_taken = 0, md_start = 0, imem_ready = 1;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy;
    logic [1:0]  stall_cause;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_stall_ctrl #(.MD_CYCLES(4), .REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_md(id_is_md), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .md_start(md_start), .imem_ready(imem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .md_busy(md_busy), .stall_cause(stall_cause),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_use_rs = 0; id_use_rt = 0; id_is_md = 0; ex_mem_read = 0;
        branch_taken = 0; md_start = 0; imem_ready = 1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rst_pc_write: got %b want 0", pc_write); end
        checks++; if (if_id_write !== 1'b0) begin errors++; $display("FAIL rst_if_id_write: got %b want 0", if_id_write); end
        checks++; if (if_id_flush !== 1'b1) begin errors++; $display("FAIL rst_if_id_flush: got %b want 1", if_id_flush); end
        checks++; if (id_ex_flush !== 1'b1) begin errors++; $display("FAIL rst_id_ex_flush: got %b want 1", id_ex_flush); end
        checks++; if (stall_cause !== 2'd0) begin errors++; $display("FAIL rst_cause: got %0d want 0", stall_cause); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rst_md_busy: got %b want 0", md_busy); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin errors++; $display("FAIL run_pc_if_write: got %b/%b want 1/1", pc_write, if_id_write); end
        checks++; if (if_id_flush !== 1'b0 || id_ex_flush !== 1'b0) begin errors++; $display("FAIL run_flushes: got %b/%b want 0/0", if_id_flush, id_ex_flush); end
        @(posedge clk); #1;
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL run_stall_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_load_use();
        // rs match
        @(posedge clk); #1;
        set_idle(); ex_mem_read = 1; ex_rd = 5'd8; id_use_rs = 1; id_rs = 5'd8;
        #1;
        checks++; if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin errors++; $display("FAIL lu_rs_write: got %b/%b want 0/0", pc_write, if_id_write); end
        checks++; if (if_id_flush !== 1'b0 || id_ex_flush !== 1'b1) begin errors++; $display("FAIL lu_rs_flush: got %b/%b want 0/1", if_id_flush, id_ex_flush); end
        checks++; if (stall_cause !== 2'd1) begin errors++; $display("FAIL lu_rs_cause: got %0d want 1", stall_cause); end
        exp_stall++;
        @(posedge clk); #1;
        set_idle();
        #1;
        checks++; if (stall_cnt !== 16'(PERF ? exp_stall : 0)) begin errors++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, PERF ? exp_stall : 0); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_one_cycle: got %b want 1", pc_write); end
        // ex_rd = 0 never hazards
        @(posedge clk); #1;
        ex_mem_read = 1; ex_rd = 5'd0; id_use_rs = 1; id_rs = 5'd0;
        #1;
        checks++; if (pc_write !== 1'b1 || stall_cause !== 2'd0) begin errors++; $display("FAIL lu_rd0: got pc_write=%b cause=%0d want 1/0", pc_write, stall_cause); end
        // rt match
        @(posedge clk); #1;
        set_idle(); ex_mem_read = 1; ex_rd = 5'd17; id_use_rt = 1; id_rt = 5'd17; id_rs = 5'd17;
        #1;
        checks++; if (pc_write !== 1'b0 || stall_cause !== 2'd1) begin errors++; $display("FAIL lu_rt: got pc_write=%b cause=%0d want 0/1", pc_write, stall_cause); end
        exp_stall++;
        // match but register not read
        @(posedge clk); #1;
        set_idle(); ex_mem_read = 1; ex_rd = 5'd9; id_rs = 5'd9; id_rt = 5'd9;
        #1;
        checks++; if (pc_write !== 1'b1 || stall_cause !== 2'd0) begin errors++; $display("FAIL lu_unused: got pc_write=%b cause=%0d want 1/0", pc_write, stall_cause); end
        // not a load
        @(posedge clk); #1;
        set_idle(); ex_rd = 5'd9; id_use_rs = 1; id_rs = 5'd9;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_not_load: got %b want 1", pc_write); end
    endtask

    task automatic test_md_busy();
        @(posedge clk); #1;
        set_idle(); md_start = 1;
        #1;
        checks++; if (md_busy !== 1'b0 || pc_write !== 1'b1) begin errors++; $display("FAIL md_issue: got busy=%b pc_write=%b want 0/1", md_busy, pc_write); end
        @(posedge clk); #1;
        md_start = 0; id_is_md = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL md_busy_c%0d: got %b want 1", i, md_busy); end
            checks++; if (pc_write !== 1'b0 || if_id_write !== 1'b0 || if_id_flush !== 1'b0 || id_ex_flush !== 1'b1) begin
                errors++; $display("FAIL md_stall_c%0d: got %b%b%b%b want 0001", i, pc_write, if_id_write, if_id_flush, id_ex_flush); end
            checks++; if (stall_cause !== 2'd2) begin errors++; $display("FAIL md_cause_c%0d: got %0d want 2", i, stall_cause); end
            exp_stall++;
            @(posedge clk); #1;
        end
        #1;
        checks++; if (md_busy !== 1'b0 || pc_write !== 1'b1 || stall_cause !== 2'd0) begin
            errors++; $display("FAIL md_done: got busy=%b pc_write=%b cause=%0d want 0/1/0", md_busy, pc_write, stall_cause); end
        checks++; if (stall_cnt !== 16'(PERF ? exp_stall : 0)) begin errors++; $display("FAIL md_stall_cnt: got %0d want %0d", stall_cnt, PERF ? exp_stall : 0); end
    endtask

    task automatic test_md_independent();
        @(posedge clk); #1;
        set_idle(); md_start = 1;
        @(posedge clk); #1;
        md_start = 0;
        #1;
        checks++; if (md_busy !== 1'b1 || pc_write !== 1'b1 || stall_cause !== 2'd0) begin
            errors++; $display("FAIL md_nonmd: got busy=%b pc_write=%b cause=%0d want 1/1/0", md_busy, pc_write, stall_cause); end
        @(posedge clk); #1;
        branch_taken = 1;
        #1;
        checks++; if (pc_write !== 1'b1 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b1) begin
            errors++; $display("FAIL md_branch: got %b%b%b want 111", pc_write, if_id_flush, id_ex_flush); end
        exp_flush++;
        @(posedge clk); #1;
        branch_taken = 0;
        #1;
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL md_not_aborted: got %b want 1", md_busy); end
        checks++; if (flush_cnt !== 16'(PERF ? exp_flush : 0)) begin errors++; $display("FAIL md_flush_cnt: got %0d want %0d", flush_cnt, PERF ? exp_flush : 0); end
        @(posedge clk); #1;
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL md_last_cycle: got %b want 1", md_busy); end
        @(posedge clk); #1;
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL md_len: got %b want 0", md_busy); end
    endtask

    task automatic test_branch_over_stall();
        @(posedge clk); #1;
        set_idle(); ex_mem_read = 1; ex_rd = 5'd8; id_use_rs = 1; id_rs = 5'd8; branch_taken = 1;
        #1;
        checks++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin errors++; $display("FAIL br_write: got %b/%b want 1/1", pc_write, if_id_write); end
        checks++; if (if_id_flush !== 1'b1 || id_ex_flush !== 1'b1) begin errors++; $display("FAIL br_flush: got %b/%b want 1/1", if_id_flush, id_ex_flush); end
        checks++; if (stall_cause !== 2'd0) begin errors++; $display("FAIL br_cause: got %0d want 0", stall_cause); end
        exp_flush++;
        @(posedge clk); #1;
        set_idle();
        checks++; if (flush_cnt !== 16'(PERF ? exp_flush : 0)) begin errors++; $display("FAIL br_flush_cnt: got %0d want %0d", flush_cnt, PERF ? exp_flush : 0); end
        checks++; if (stall_cnt !== 16'(PERF ? exp_stall : 0)) begin errors++; $display("FAIL br_stall_cnt: got %0d want %0d", stall_cnt, PERF ? exp_stall : 0); end
    endtask

    task automatic test_imem();
        @(posedge clk); #1;
        set_idle(); imem_ready = 0; ex_mem_read = 1; ex_rd = 5'd3; id_use_rt = 1; id_rt = 5'd3;
        #1;
        checks++; if (if_id_write !== 1'b0 || if_id_flush !== 1'b0 || pc_write !== 1'b0) begin
            errors++; $display("FAIL im_lu_hold: got wr=%b fl=%b pc=%b want 0/0/0", if_id_write, if_id_flush, pc_write); end
        checks++; if (stall_cause !== 2'd1) begin errors++; $display("FAIL im_lu_cause: got %0d want 1", stall_cause); end
        exp_stall++;
        @(posedge clk); #1;
        ex_mem_read = 0;
        #1;
        checks++; if (if_id_write !== 1'b1 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b0 || pc_write !== 1'b0) begin
            errors++; $display("FAIL im_only: got wr=%b fl=%b ex=%b pc=%b want 1/1/0/0", if_id_write, if_id_flush, id_ex_flush, pc_write); end
        checks++; if (stall_cause !== 2'd3) begin errors++; $display("FAIL im_cause: got %0d want 3", stall_cause); end
        exp_stall++;
        @(posedge clk); #1;
        set_idle();
        checks++; if (stall_cnt !== 16'(PERF ? exp_stall : 0)) begin errors++; $display("FAIL im_stall_cnt: got %0d want %0d", stall_cnt, PERF ? exp_stall : 0); end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        set_idle(); md_start = 1;
        @(posedge clk); #1;
        md_start = 0;
        @(posedge clk); #1;
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL ar_pre: got %b want 1", md_busy); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL ar_busy_drop: got %b want 0", md_busy); end
        checks++; if (pc_write !== 1'b0 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b1) begin
            errors++; $display("FAIL ar_outputs: got pc=%b fl=%b ex=%b want 0/1/1", pc_write, if_id_flush, id_ex_flush); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL ar_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        exp_stall = 0; exp_flush = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (md_busy !== 1'b0 || pc_write !== 1'b1) begin errors++; $display("FAIL ar_release: got busy=%b pc=%b want 0/1", md_busy, pc_write); end
        @(posedge clk); #1;
        id_is_md = 1;
        #1;
        checks++; if (md_busy !== 1'b0 || pc_write !== 1'b1) begin errors++; $display("FAIL ar_run: got busy=%b pc=%b want 0/1", md_busy, pc_write); end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_md_busy();
        test_md_independent();
        test_branch_over_stall();
        test_imem();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_hazard_stall_ctrl
`default_nettype wire
